// File: rtl/counter_sequencer.sv
// counter_sequencer: start/stop/pause sequencer for a WIDTH-bit up-counter.
// Runs one-shot or auto-reload periods of (limit+1) cycles and emits a
// registered single-cycle done pulse at the end of each period.
// Optional build macro COUNTER_SEQUENCER_PERIOD_CNT_EN adds an 8-bit
// saturating count of completed periods (period_cnt_out).
module counter_sequencer #(
    parameter int WIDTH = 3
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             start_in,
    input  logic             stop_in,
    input  logic             pause_in,
    input  logic             reload_in,
    input  logic [WIDTH-1:0] limit_in,
    output logic [WIDTH-1:0] count_out,
    output logic             busy_out,
    output logic             done_out
`ifdef COUNTER_SEQUENCER_PERIOD_CNT_EN
    ,
    output logic [7:0]       period_cnt_out
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   count_q;
    logic [WIDTH-1:0]   count_d;
    logic [WIDTH-1:0]   limit_q;
    logic [WIDTH-1:0]   limit_d;
    logic               reload_q;
    logic               reload_d;
    logic               busy_q;
    logic               busy_d;
    logic               done_q;
    logic               done_d;

    logic               start_accept_s;
    logic               terminal_s;

    // Stop outranks start in IDLE, so a start is only accepted without stop.
    assign start_accept_s = (state_q == ST_IDLE) && start_in && !stop_in;
    assign terminal_s     = (count_q == limit_q);

    // State and datapath registers; synchronous reset clears everything.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q  <= ST_IDLE;
            count_q  <= {WIDTH{1'b0}};
            limit_q  <= {WIDTH{1'b0}};
            reload_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            limit_q  <= limit_d;
            reload_q <= reload_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state selection: stop > pause > terminal > keep running.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_accept_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop_in) begin
                    state_d = ST_IDLE;
                end else if (pause_in) begin
                    state_d = ST_HOLD;
                end else if (terminal_s && !reload_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HOLD: begin
                if (stop_in) begin
                    state_d = ST_IDLE;
                end else if (!pause_in) begin
                    // Resume without counting; terminal check happens in RUN.
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Count, latched configuration and done pulse for the next cycle.
    always_comb begin
        count_d  = count_q;
        limit_d  = limit_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_accept_s) begin
                    count_d  = {WIDTH{1'b0}};
                    limit_d  = limit_in;
                    reload_d = reload_in;
                end else begin
                    count_d  = count_q;
                end
            end
            ST_RUN: begin
                if (stop_in) begin
                    count_d = {WIDTH{1'b0}};
                end else if (pause_in) begin
                    count_d = count_q;
                end else if (terminal_s) begin
                    done_d = 1'b1;
                    if (reload_q) begin
                        count_d = {WIDTH{1'b0}};
                    end else begin
                        // One-shot finishes with the limit left on the output.
                        count_d = count_q;
                    end
                end else begin
                    // limit never exceeds the max count, so no wrap occurs here.
                    count_d = count_q + WIDTH'(1);
                end
            end
            ST_HOLD: begin
                if (stop_in) begin
                    count_d = {WIDTH{1'b0}};
                end else begin
                    count_d = count_q;
                end
            end
            default: begin
                count_d = {WIDTH{1'b0}};
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    assign count_out = count_q;
    assign busy_out  = busy_q;
    assign done_out  = done_q;

`ifdef COUNTER_SEQUENCER_PERIOD_CNT_EN
    logic [7:0] period_q;
    logic [7:0] period_d;

    // Period counter: cleared on start, steps with each done, saturates at 255.
    always_comb begin
        if (start_accept_s) begin
            period_d = 8'd0;
        end else if (done_d && (period_q != 8'd255)) begin
            period_d = period_q + 8'd1;
        end else begin
            period_d = period_q;
        end
    end

    // Period counter register, aligned with the done_out register.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            period_q <= 8'd0;
        end else begin
            period_q <= period_d;
        end
    end

    assign period_cnt_out = period_q;
`endif

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer (WIDTH=3): a vector table,
// hand-written corner sequences and a randomized run against a reference model.
module tb_counter_sequencer;

    logic       clk_in;
    logic       reset_in;
    logic       start_in;
    logic       stop_in;
    logic       pause_in;
    logic       reload_in;
    logic [2:0] limit_in;
    logic [2:0] count_out;
    logic       busy_out;
    logic       done_out;
`ifdef COUNTER_SEQUENCER_PERIOD_CNT_EN
    logic [7:0] period_cnt_out;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    counter_sequencer #(.WIDTH(3)) dut (
        .clk_in    (clk_in),
        .reset_in  (reset_in),
        .start_in  (start_in),
        .stop_in   (stop_in),
        .pause_in  (pause_in),
        .reload_in (reload_in),
        .limit_in  (limit_in),
        .count_out (count_out),
        .busy_out  (busy_out),
        .done_out  (done_out)
`ifdef COUNTER_SEQUENCER_PERIOD_CNT_EN
        ,
        .period_cnt_out (period_cnt_out)
`endif
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        logic       rst;
        logic       start;
        logic       stop;
        logic       pause;
        logic       rel;
        logic [2:0] lim;
        logic [2:0] exp_count;
        logic       exp_busy;
        logic       exp_done;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic s, input logic st,
                                input logic pa, input logic rl, input logic [2:0] lim,
                                input logic [2:0] ec, input logic eb, input logic ed);
        vec_t v;
        v.rst = r; v.start = s; v.stop = st; v.pause = pa; v.rel = rl; v.lim = lim;
        v.exp_count = ec; v.exp_busy = eb; v.exp_done = ed;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic st,
                         input logic pa, input logic rl, input logic [2:0] lim);
        reset_in = r; start_in = s; stop_in = st; pause_in = pa;
        reload_in = rl; limit_in = lim;
    endtask

    // Inputs change #1 after a rising edge; outputs are sampled #1 after the next one.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic apply(input vec_t v, input string tag);
        drive(v.rst, v.start, v.stop, v.pause, v.rel, v.lim);
        step();
        chk({tag, "_count"}, int'(count_out), int'(v.exp_count));
        chk({tag, "_busy"},  int'(busy_out),  int'(v.exp_busy));
        chk({tag, "_done"},  int'(done_out),  int'(v.exp_done));
    endtask

    // Reference model: running/frozen flags plus the count, computed from the rules.
    bit m_active, m_frozen, m_rel, m_done;
    int m_cnt, m_lim, m_pc;

    task automatic model_step(input logic r, input logic s, input logic st,
                              input logic pa, input logic rl, input logic [2:0] lim);
        m_done = 1'b0;
        if (r) begin
            m_active = 0; m_frozen = 0; m_rel = 0; m_cnt = 0; m_lim = 0; m_pc = 0;
        end else if (!m_active) begin
            if (!st && s) begin
                m_lim = int'(lim); m_rel = rl; m_cnt = 0; m_active = 1; m_frozen = 0; m_pc = 0;
            end
        end else if (st) begin
            m_active = 0; m_frozen = 0; m_cnt = 0;
        end else if (m_frozen) begin
            if (!pa) m_frozen = 0;
        end else if (pa) begin
            m_frozen = 1;
        end else if (m_cnt == m_lim) begin
            m_done = 1'b1;
            if (m_pc < 255) m_pc++;
            if (m_rel) m_cnt = 0;
            else m_active = 0;
        end else begin
            m_cnt++;
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

        // Reset with start held, one-shot, start+stop in IDLE, auto-reload.
        tbl.push_back(mk(1,1,0,0,0,3'd0, 3'd0,0,0));
        tbl.push_back(mk(1,1,0,0,0,3'd0, 3'd0,0,0));
        tbl.push_back(mk(0,0,0,0,0,3'd0, 3'd0,0,0));
        tbl.push_back(mk(0,1,0,0,0,3'd5, 3'd0,1,0));
        for (int i = 1; i <= 5; i++)
            tbl.push_back(mk(0,0,0,0,0,3'd5, 3'(i),1,0));
        tbl.push_back(mk(0,0,0,0,0,3'd5, 3'd5,0,1));
        tbl.push_back(mk(0,0,0,0,0,3'd5, 3'd5,0,0));
        tbl.push_back(mk(0,1,1,0,0,3'd3, 3'd5,0,0));
        tbl.push_back(mk(0,0,0,1,0,3'd0, 3'd5,0,0));
        tbl.push_back(mk(0,1,0,0,1,3'd2, 3'd0,1,0));
        // Mid-run limit/mode changes and a repeated start must have no effect.
        for (int i = 1; i <= 9; i++)
            tbl.push_back(mk(0,(i == 4),0,0,0,3'd7, 3'(i % 3),1,(i % 3 == 0)));
        tbl.push_back(mk(0,0,1,0,0,3'd7, 3'd0,0,0));

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], $sformatf("tbl%0d", i));

        // Pause at count 3 for 4 cycles, then pause on the terminal cycle.
        apply(mk(0,1,0,0,0,3'd7, 3'd0,1,0), "pz_start");
        for (int i = 1; i <= 3; i++)
            apply(mk(0,0,0,0,0,3'd7, 3'(i),1,0), "pz_run");
        for (int i = 0; i < 4; i++)
            apply(mk(0,0,0,1,0,3'd7, 3'd3,1,0), "pz_hold");
        apply(mk(0,0,0,0,0,3'd7, 3'd3,1,0), "pz_release");
        for (int i = 4; i <= 7; i++)
            apply(mk(0,0,0,0,0,3'd7, 3'(i),1,0), "pz_resume");
        apply(mk(0,0,0,1,0,3'd7, 3'd7,1,0), "pzt_hold1");
        apply(mk(0,0,0,1,0,3'd7, 3'd7,1,0), "pzt_hold2");
        apply(mk(0,0,0,0,0,3'd7, 3'd7,1,0), "pzt_release");
        apply(mk(0,0,0,0,0,3'd7, 3'd7,0,1), "pzt_done");
        apply(mk(0,0,0,0,0,3'd7, 3'd7,0,0), "pzt_idle");

        // Stop at count 4.
        apply(mk(0,1,0,0,1,3'd7, 3'd0,1,0), "st_start");
        for (int i = 1; i <= 4; i++)
            apply(mk(0,0,0,0,1,3'd7, 3'(i),1,0), "st_run");
        apply(mk(0,0,1,0,1,3'd7, 3'd0,0,0), "st_stop");
        apply(mk(0,0,0,0,1,3'd7, 3'd0,0,0), "st_idle");

        // limit = 0 auto-reload: done every cycle, long enough to saturate.
        apply(mk(0,1,0,0,1,3'd0, 3'd0,1,0), "l0_start");
        for (int i = 0; i < 300; i++) begin
            apply(mk(0,0,0,0,1,3'd0, 3'd0,1,1), "l0_run");
`ifdef COUNTER_SEQUENCER_PERIOD_CNT_EN
            chk("l0_period", int'(period_cnt_out), (i + 1 > 255) ? 255 : i + 1);
`endif
        end
        // Reset mid-run suppresses the in-flight done.
        apply(mk(1,0,0,0,1,3'd0, 3'd0,0,0), "rst_mid");
`ifdef COUNTER_SEQUENCER_PERIOD_CNT_EN
        chk("rst_mid_period", int'(period_cnt_out), 0);
`endif

        // Randomized run against the reference model.
        model_step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 3000; i++) begin
            logic r, s, st, pa, rl;
            logic [2:0] lim;
            r   = ($urandom_range(0, 199) == 0);
            s   = ($urandom_range(0, 2) == 0);
            st  = ($urandom_range(0, 24) == 0);
            pa  = ($urandom_range(0, 5) == 0);
            rl  = 1'($urandom_range(0, 1));
            lim = 3'($urandom_range(0, 7));
            model_step(r, s, st, pa, rl, lim);
            drive(r, s, st, pa, rl, lim);
            step();
            chk("rnd_count", int'(count_out), m_cnt);
            chk("rnd_busy",  int'(busy_out),  int'(m_active));
            chk("rnd_done",  int'(done_out),  int'(m_done));
`ifdef COUNTER_SEQUENCER_PERIOD_CNT_EN
            chk("rnd_period", int'(period_cnt_out), m_pc);
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
Control sequencer for the team's WIDTH-bit up-counters, default 3 bits to match the existing ripple counter.
- Accepts start/stop/pause commands and a programmable terminal value.
- Runs the count in one-shot or auto-reload mode and flags each completed period with a single-cycle done pulse.
- Sits between the control logic and any counter-driven datapath as the single owner of count sequencing.

Parameters:
- WIDTH, 3, count and limit width in bits; must be at least 1.

Ports:
- clk_in  input  1  system clock; all state updates on the rising edge.
- reset_in  input  1  synchronous, active-high reset.
- start_in  input  1  start request; sampled only in IDLE.
- stop_in  input  1  abort request; valid in RUN and HOLD.
- pause_in  input  1  level; freezes the count while high (RUN/HOLD only).
- reload_in  input  1  mode, latched at start: 1 = auto-reload, 0 = one-shot.
- limit_in  input  WIDTH  terminal count, latched at start.
- count_out  output  WIDTH  current count, registered.
- busy_out  output  1  high in RUN or HOLD.
- done_out  output  1  one-cycle pulse, registered, marks completion of a period.

Behaviour:
- Clock is clk_in. reset_in is synchronous and active-high, and overrides everything else.
- Reset values:
  - state = IDLE
  - count_out = 0, busy_out = 0, done_out = 0
  - latched limit = 0, latched mode = 0
- States: IDLE, RUN, HOLD. done_out defaults to 0 every cycle unless set below.
- IDLE:
  - stop_in = 1: stay IDLE. This takes priority over a simultaneous start.
  - else start_in = 1: latch limit_in and reload_in, count_out <= 0, go to RUN. busy_out = 1 from the next cycle.
  - pause_in is ignored in IDLE.
  - count_out holds its last value.
- RUN, priority is stop > pause > terminal > increment:
  - stop_in: go to IDLE, count_out <= 0, no done pulse.
  - pause_in: go to HOLD, count frozen.
  - count_out == latched limit (terminal):
    - done_out <= 1.
    - Reload mode: count_out <= 0, stay in RUN.
    - One-shot mode: go to IDLE, count_out holds the limit.
  - otherwise: count_out <= count_out + 1.
- HOLD:
  - stop_in: go to IDLE, count_out <= 0.
  - pause_in low: return to RUN. Counting resumes the following cycle, and the terminal check is re-evaluated then.
- Period length is limit+1 cycles (counts 0..L). With limit = 0 the period is 1 cycle and done pulses every RUN cycle.
- limit_in never exceeds 2^WIDTH-1, so count never wraps past the limit; no modulo arithmetic is needed.
- start_in in RUN or HOLD is ignored (no restart). limit_in and reload_in changes after start have no effect.
- Pause asserted on the terminal cycle: pause wins, there is no done pulse, and the count is held at the limit. Done fires on the first RUN cycle after resume.
- Reset mid-run: next cycle is IDLE with all outputs 0. An in-flight done pulse is suppressed.

Optional Feature:
- Macro: COUNTER_SEQUENCER_PERIOD_CNT_EN.
- Defined:
  - Adds output period_cnt_out, 8 bits.
  - Increments on each done_out pulse, in the same cycle done_out asserts.
  - Saturates at 255.
  - Cleared by reset_in and on each accepted start.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan (WIDTH=3):
- reset_in=1 for 2 cycles, start_in=1 held → count_out=0, busy_out=0, done_out=0, stays IDLE.
- One-shot: limit=5, reload=0, start pulse → count 0,1,2,3,4,5 over 6 cycles, done_out=1 for one cycle, then busy=0 with count held at 5.
- Auto-reload: limit=2, reload=1, run 9 cycles → counts 0,1,2,0,1,2,0,1,2, three done pulses 3 cycles apart, busy stays 1.
- Pause at count=3 for 4 cycles (limit=7) → count stays 3 throughout, busy=1, then resumes 4,5...; pause on terminal cycle → no done until the cycle after release.
- stop_in at count=4 → next cycle IDLE, count=0, no done; start+stop together in IDLE → remains IDLE.
- limit=0 reload=1 → done every cycle, count constant 0; with the macro defined, period_cnt_out reaches 255 and saturates; reset mid-run → all outputs 0 next cycle.
